// File: rtl/hdlc_host_ctrl_pkg.sv
// hdlc_host_pkg: Hdlc register map, control/status bit indices,
// bus widths and the host controller FSM state type.
package hdlc_host_pkg;

  localparam int AW = 3;
  localparam int DW = 8;

  localparam logic [AW-1:0] A_TX_SC   = 3'd0;
  localparam logic [AW-1:0] A_TX_BUFF = 3'd1;
  localparam logic [AW-1:0] A_RX_SC   = 3'd2;
  localparam logic [AW-1:0] A_RX_BUFF = 3'd3;
  localparam logic [AW-1:0] A_RX_LEN  = 3'd4;

  localparam logic [2:0] TXSC_EN    = 3'd1;
  localparam logic [2:0] TXSC_ABORT = 3'd2;
  localparam logic [2:0] RXSC_DROP  = 3'd1;
  localparam logic [2:0] RXSC_FERR  = 3'd3;
  localparam logic [2:0] RXSC_ABORT = 3'd4;
  localparam logic [2:0] RXSC_OVF   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_WR,
    S_TX_GO,
    S_TX_WAIT,
    S_RX_LEN,
    S_RX_STAT,
    S_RX_BYTE,
    S_RX_DROP
  } state_e;

  function automatic logic [DW-1:0] bmask(input logic [2:0] idx);
    logic [DW-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/hdlc_host_ctrl_if.sv
// hdlc_host_ctrl_if: Hdlc register slave port (Address, strobes,
// DataIn/DataOut) plus Rx_Ready/Tx_Done status lines.
interface hdlc_host_ctrl_if;
  import hdlc_host_pkg::*;

  logic [AW-1:0] Address;
  logic          WriteEnable;
  logic          ReadEnable;
  logic [DW-1:0] DataIn;
  logic [DW-1:0] DataOut;
  logic          Rx_Ready;
  logic          Tx_Done;

  modport master (
    output Address, WriteEnable, ReadEnable, DataIn,
    input  DataOut, Rx_Ready, Tx_Done
  );

  modport slave (
    input  Address, WriteEnable, ReadEnable, DataIn,
    output DataOut, Rx_Ready, Tx_Done
  );

endinterface

// File: rtl/hdlc_reg_rd.sv
// hdlc_reg_rd: one-cycle read strobe, waits RD_LAT cycles, then
// returns rd_data_o with rd_valid_o. Ports: start/addr in, strobe out.
module hdlc_reg_rd
  import hdlc_host_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] dout_i,
  output logic          re_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_valid_o
);

  localparam logic [1:0] LAT = 2'(RD_LAT);

  logic       pend_q, pend_d;
  logic [1:0] cnt_q, cnt_d;

  // start_i is ignored while a read is outstanding, so the
  // caller may hold it high until rd_valid_o.
  always_comb begin
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    re_o       = 1'b0;
    addr_o     = '0;
    rd_data_o  = '0;
    rd_valid_o = 1'b0;
    if (!pend_q) begin
      if (start_i) begin
        re_o   = 1'b1;
        addr_o = addr_i;
        pend_d = 1'b1;
        cnt_d  = 2'd1;
      end
    end else if (cnt_q == LAT) begin
      rd_valid_o = 1'b1;
      rd_data_o  = dout_i;
      pend_d     = 1'b0;
      cnt_d      = '0;
    end else begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/hdlc_host_ctrl.sv
// hdlc_host_ctrl: drives the Hdlc register port from a TX byte
// stream and drains RX frames to an RX byte stream.
module hdlc_host_ctrl
  import hdlc_host_pkg::*;
#(
  parameter int RD_LAT       = 1,
  parameter int MAX_TX_BYTES = 126
) (
  input  logic             Clk,
  input  logic             Rst,
  hdlc_host_ctrl_if.master hdlc,
  input  logic [DW-1:0]    s_tx_data,
  input  logic             s_tx_valid,
  input  logic             s_tx_last,
  output logic             s_tx_ready,
  input  logic             tx_abort,
  output logic [DW-1:0]    m_rx_data,
  output logic             m_rx_valid,
  output logic             m_rx_last,
  input  logic             m_rx_ready,
  output logic             tx_frame_done,
  output logic             tx_ovf,
  output logic             rx_err,
  output logic             busy
);

  localparam logic [6:0] MAXB = 7'(MAX_TX_BYTES);

  state_e        state_q, state_d;
  state_e        ret_q, ret_d;
  logic [6:0]    tx_cnt_q, tx_cnt_d;
  logic          ovf_q, ovf_d;
  logic          drop_q, drop_d;
  logic [1:0]    gcnt_q, gcnt_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    bcnt_q, bcnt_d;
  logic [DW-1:0] rxd_q, rxd_d;
  logic          rxv_q, rxv_d;
  logic          rxl_q, rxl_d;

  logic          wr_en;
  logic [AW-1:0] wr_a;
  logic [DW-1:0] wr_d;
  logic          rd_go;
  logic [AW-1:0] rd_a;
  logic          rd_re;
  logic [AW-1:0] rd_ao;
  logic [DW-1:0] rd_data;
  logic          rd_vld;

  hdlc_reg_rd #(.RD_LAT(RD_LAT)) u_rd (
    .clk_i      (Clk),
    .rst_n_i    (Rst),
    .start_i    (rd_go),
    .addr_i     (rd_a),
    .dout_i     (hdlc.DataOut),
    .re_o       (rd_re),
    .addr_o     (rd_ao),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_vld)
  );

  assign hdlc.WriteEnable = wr_en;
  assign hdlc.ReadEnable  = rd_re;
  assign hdlc.Address     = wr_en ? wr_a : rd_ao;
  assign hdlc.DataIn      = wr_d;

  assign m_rx_data  = rxd_q;
  assign m_rx_valid = rxv_q;
  assign m_rx_last  = rxl_q;
  assign tx_ovf     = ovf_q;
  assign busy       = (state_q != S_IDLE);

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    tx_cnt_d      = tx_cnt_q;
    ovf_d         = ovf_q;
    drop_d        = drop_q;
    len_d         = len_q;
    bcnt_d        = bcnt_q;
    rxd_d         = rxd_q;
    rxv_d         = rxv_q;
    rxl_d         = rxl_q;
    wr_en         = 1'b0;
    wr_a          = '0;
    wr_d          = '0;
    rd_go         = 1'b0;
    rd_a          = '0;
    s_tx_ready    = 1'b0;
    tx_frame_done = 1'b0;
    rx_err        = 1'b0;
    // cycles since TX_GO, saturating; Tx_Done is stale before 2
    gcnt_d = (gcnt_q == 2'd2) ? gcnt_q : gcnt_q + 2'd1;

    if (rxv_q && m_rx_ready) begin
      rxv_d = 1'b0;
      rxl_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (hdlc.Rx_Ready) begin
          ret_d   = S_IDLE;
          state_d = S_RX_LEN;
        end else if (s_tx_valid) begin
          state_d  = S_TX_WR;
          tx_cnt_d = '0;
          ovf_d    = 1'b0;
          drop_d   = 1'b0;
        end
      end
      S_TX_WR: begin
        s_tx_ready = 1'b1;
        if (tx_abort && !drop_q) begin
          wr_en = 1'b1;
          wr_a  = A_TX_SC;
          wr_d  = bmask(TXSC_ABORT);
          if (s_tx_valid && s_tx_last)
            state_d = S_IDLE;
          else
            drop_d = 1'b1;
        end else if (s_tx_valid) begin
          // drop mode swallows the rest of an aborted frame
          if (!drop_q) begin
            if (tx_cnt_q < MAXB) begin
              wr_en    = 1'b1;
              wr_a     = A_TX_BUFF;
              wr_d     = s_tx_data;
              tx_cnt_d = tx_cnt_q + 7'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (s_tx_last)
            state_d = drop_q ? S_IDLE : S_TX_GO;
        end
      end
      S_TX_GO: begin
        wr_en   = 1'b1;
        wr_a    = A_TX_SC;
        wr_d    = bmask(TXSC_EN);
        gcnt_d  = 2'd1;
        state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (tx_abort) begin
          wr_en   = 1'b1;
          wr_a    = A_TX_SC;
          wr_d    = bmask(TXSC_ABORT);
          state_d = S_IDLE;
        end else if (hdlc.Tx_Done && gcnt_q == 2'd2) begin
          tx_frame_done = 1'b1;
          state_d       = S_IDLE;
        end else if (hdlc.Rx_Ready) begin
          ret_d   = S_TX_WAIT;
          state_d = S_RX_LEN;
        end
      end
      S_RX_LEN: begin
        rd_go = 1'b1;
        rd_a  = A_RX_LEN;
        if (rd_vld) begin
          len_d   = rd_data;
          bcnt_d  = '0;
          state_d = S_RX_STAT;
        end
      end
      S_RX_STAT: begin
        rd_go = 1'b1;
        rd_a  = A_RX_SC;
        if (rd_vld) begin
          if (rd_data[RXSC_FERR] || rd_data[RXSC_ABORT] ||
              rd_data[RXSC_OVF] || len_q == 8'd0)
            state_d = S_RX_DROP;
          else
            state_d = S_RX_BYTE;
        end
      end
      S_RX_BYTE: begin
        // the output register is free by the time data returns
        if (bcnt_q != len_q && (!rxv_q || m_rx_ready)) begin
          rd_go = 1'b1;
          rd_a  = A_RX_BUFF;
        end
        if (rxv_q && m_rx_ready && rxl_q)
          state_d = ret_q;
        if (rd_vld) begin
          rxd_d  = rd_data;
          rxv_d  = 1'b1;
          rxl_d  = (bcnt_q + 8'd1 == len_q);
          bcnt_d = bcnt_q + 8'd1;
        end
      end
      S_RX_DROP: begin
        wr_en   = 1'b1;
        wr_a    = A_RX_SC;
        wr_d    = bmask(RXSC_DROP);
        rx_err  = 1'b1;
        state_d = ret_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      ret_q    <= S_IDLE;
      tx_cnt_q <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 1'b0;
      gcnt_q   <= '0;
      len_q    <= '0;
      bcnt_q   <= '0;
      rxd_q    <= '0;
      rxv_q    <= 1'b0;
      rxl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      tx_cnt_q <= tx_cnt_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      gcnt_q   <= gcnt_d;
      len_q    <= len_d;
      bcnt_q   <= bcnt_d;
      rxd_q    <= rxd_d;
      rxv_q    <= rxv_d;
      rxl_q    <= rxl_d;
    end
  end

endmodule

// File: tb/tb_hdlc_host_ctrl.sv
// tb_hdlc_host_ctrl: directed TX/RX/abort/overflow/reset vectors
// against a small Hdlc register-slave model.
module tb_hdlc_host_ctrl;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Rst;
  logic [7:0] s_tx_data;
  logic       s_tx_valid, s_tx_last, s_tx_ready, tx_abort;
  logic [7:0] m_rx_data;
  logic       m_rx_valid, m_rx_last, m_rx_ready;
  logic       tx_frame_done, tx_ovf, rx_err, busy;

  hdlc_host_ctrl_if bus();

  hdlc_host_ctrl #(.RD_LAT(1), .MAX_TX_BYTES(126)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .hdlc          (bus),
    .s_tx_data     (s_tx_data),
    .s_tx_valid    (s_tx_valid),
    .s_tx_last     (s_tx_last),
    .s_tx_ready    (s_tx_ready),
    .tx_abort      (tx_abort),
    .m_rx_data     (m_rx_data),
    .m_rx_valid    (m_rx_valid),
    .m_rx_last     (m_rx_last),
    .m_rx_ready    (m_rx_ready),
    .tx_frame_done (tx_frame_done),
    .tx_ovf        (tx_ovf),
    .rx_err        (rx_err),
    .busy          (busy)
  );

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  logic [10:0] wr_log[$];
  logic [8:0]  rx_out[$];
  logic [7:0]  rxbuf[$];
  logic [7:0]  rx_len_v, rx_sc_v;
  int rd_cnt[8];
  int done_cnt = 0, err_cnt = 0, viol = 0, stab_bad = 0;
  int cyc = 0, go_cyc = 0, done_cyc = 0;
  logic       hold_q = 1'b0;
  logic [7:0] hold_d = 8'h00;

  // slave model and bus monitor; sampled mid-cycle
  always @(negedge Clk) begin
    cyc++;
    if (bus.WriteEnable) begin
      wr_log.push_back({bus.Address, bus.DataIn});
      if (bus.Address == 3'd0 && bus.DataIn == 8'h02) go_cyc = cyc;
    end
    if (bus.WriteEnable && bus.ReadEnable) viol++;
    if (!bus.WriteEnable && !bus.ReadEnable &&
        (bus.Address != 3'd0 || bus.DataIn != 8'h00)) viol++;
    if (bus.ReadEnable) begin
      rd_cnt[bus.Address]++;
      case (bus.Address)
        3'd4: bus.DataOut = rx_len_v;
        3'd2: bus.DataOut = rx_sc_v;
        3'd3: bus.DataOut = (rxbuf.size() > 0) ? rxbuf.pop_front()
                                                : 8'hEE;
        default: bus.DataOut = 8'h00;
      endcase
    end
    if (tx_frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rx_err) err_cnt++;
    if (Rst && m_rx_valid && m_rx_ready)
      rx_out.push_back({m_rx_last, m_rx_data});
    if (Rst && hold_q && (!m_rx_valid || m_rx_data != hold_d))
      stab_bad++;
    hold_q = Rst && m_rx_valid && !m_rx_ready;
    hold_d = m_rx_data;
  end

  function automatic logic [31:0] outs();
    return {4'h0, busy, s_tx_ready, m_rx_valid, m_rx_last,
            m_rx_data, tx_frame_done, tx_ovf, rx_err,
            bus.WriteEnable, bus.ReadEnable, bus.Address,
            bus.DataIn};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic clr();
    wr_log.delete();
    rx_out.delete();
    rxbuf.delete();
    foreach (rd_cnt[i]) rd_cnt[i] = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last,
                           input bit ab);
    int  k;
    bit  acc;
    k          = 0;
    acc        = 1'b0;
    s_tx_valid = 1'b1;
    s_tx_data  = d;
    s_tx_last  = last;
    tx_abort   = ab;
    while (!acc && k < 200) begin
      @(negedge Clk);
      acc = s_tx_ready;
      @(posedge Clk);
      #1;
      k++;
    end
    if (!acc) chk("tx_accept", 32'(acc), 32'd1);
    s_tx_valid = 1'b0;
    s_tx_last  = 1'b0;
    tx_abort   = 1'b0;
  endtask

  task automatic wait_wr(input int n, input string tag);
    int k = 0;
    while (wr_log.size() < n && k < 400) begin
      tick(1);
      k++;
    end
    if (wr_log.size() < n) chk(tag, wr_log.size(), n);
  endtask

  task automatic wait_rx(input int n, input string tag);
    int k = 0;
    while (rx_out.size() < n && k < 400) begin
      tick(1);
      k++;
    end
    if (rx_out.size() < n) chk(tag, rx_out.size(), n);
  endtask

  task automatic wait_done(input int n, input string tag);
    int k = 0;
    while (done_cnt < n && k < 400) begin
      tick(1);
      k++;
    end
    if (done_cnt < n) chk(tag, done_cnt, n);
  endtask

  task automatic wait_mv(input string tag);
    int k = 0;
    while (!m_rx_valid && k < 400) begin
      tick(1);
      k++;
    end
    if (!m_rx_valid) chk(tag, 32'(m_rx_valid), 32'd1);
  endtask

  task automatic rx_pulse();
    bus.Rx_Ready = 1'b1;
    tick(1);
    bus.Rx_Ready = 1'b0;
  endtask

  initial begin
    int d0, e0, n1;
    Rst         = 1'b0;
    s_tx_data   = 8'h00;
    s_tx_valid  = 1'b0;
    s_tx_last   = 1'b0;
    tx_abort    = 1'b0;
    m_rx_ready  = 1'b0;
    bus.Rx_Ready = 1'b0;
    bus.Tx_Done  = 1'b0;
    rx_len_v    = 8'h00;
    rx_sc_v     = 8'h00;
    clr();
    tick(3);
    chk("reset_outs", outs(), 32'h0);
    Rst = 1'b1;
    tick(2);

    // 3-byte TX frame
    clr();
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0);
    send_byte(8'h7E, 1'b1, 1'b0);
    wait_wr(4, "tx3_go_to");
    chk("tx3_nwr", wr_log.size(), 4);
    chk("tx3_w0", 32'(wr_log[0]), {21'h0, 3'd1, 8'hAA});
    chk("tx3_w1", 32'(wr_log[1]), {21'h0, 3'd1, 8'h55});
    chk("tx3_w2", 32'(wr_log[2]), {21'h0, 3'd1, 8'h7E});
    chk("tx3_go", 32'(wr_log[3]), {21'h0, 3'd0, 8'h02});
    tick(10);
    chk("tx3_busy_wait", 32'(busy), 32'd1);
    chk("tx3_no_early", done_cnt, 0);
    bus.Tx_Done = 1'b1;
    wait_done(1, "tx3_done_to");
    bus.Tx_Done = 1'b0;
    tick(3);
    chk("tx3_done_once", done_cnt, 1);
    chk("tx3_idle", 32'(busy), 32'd0);
    chk("tx3_ovf", 32'(tx_ovf), 32'd0);

    // RX frame with back-pressure
    clr();
    rx_len_v = 8'd2;
    rx_sc_v  = 8'h01;
    rxbuf.push_back(8'h11);
    rxbuf.push_back(8'h22);
    rx_pulse();
    wait_mv("rx_valid_to");
    chk("rx_b0_data", 32'(m_rx_data), 32'h11);
    chk("rx_b0_last", 32'(m_rx_last), 32'd0);
    tick(5);
    chk("rx_stall_reads", rd_cnt[3], 1);
    chk("rx_stall_data", 32'(m_rx_data), 32'h11);
    chk("rx_stall_valid", 32'(m_rx_valid), 32'd1);
    m_rx_ready = 1'b1;
    wait_rx(2, "rx_out_to");
    m_rx_ready = 1'b0;
    tick(2);
    chk("rx_o0", 32'(rx_out[0]), 32'h011);
    chk("rx_o1", 32'(rx_out[1]), 32'h122);
    chk("rx_nlen", rd_cnt[4], 1);
    chk("rx_nsc", rd_cnt[2], 1);
    chk("rx_nbuf", rd_cnt[3], 2);
    chk("rx_idle", 32'(busy), 32'd0);
    chk("rx_no_wr", wr_log.size(), 0);

    // RX FrameError -> drop
    clr();
    e0 = err_cnt;
    rx_len_v = 8'd2;
    rx_sc_v  = 8'h08;
    rxbuf.push_back(8'h99);
    rx_pulse();
    tick(10);
    chk("ferr_err", err_cnt, e0 + 1);
    chk("ferr_nwr", wr_log.size(), 1);
    chk("ferr_w", 32'(wr_log[0]), {21'h0, 3'd2, 8'h02});
    chk("ferr_nout", rx_out.size(), 0);
    chk("ferr_nbuf", rd_cnt[3], 0);

    // RX with zero length -> drop
    clr();
    e0 = err_cnt;
    rx_len_v = 8'd0;
    rx_sc_v  = 8'h00;
    rx_pulse();
    tick(10);
    chk("len0_err", err_cnt, e0 + 1);
    chk("len0_nbuf", rd_cnt[3], 0);

    // 130-byte TX frame, overflow
    clr();
    d0 = done_cnt;
    for (int i = 0; i < 130; i++)
      send_byte(8'(i), i == 129, 1'b0);
    wait_wr(127, "ovf_go_to");
    n1 = 0;
    foreach (wr_log[i]) if (wr_log[i][10:8] == 3'd1) n1++;
    chk("ovf_nbuf", n1, 126);
    chk("ovf_nwr", wr_log.size(), 127);
    chk("ovf_w125", 32'(wr_log[125]), {21'h0, 3'd1, 8'd125});
    chk("ovf_go", 32'(wr_log[126]), {21'h0, 3'd0, 8'h02});
    chk("ovf_flag", 32'(tx_ovf), 32'd1);
    tick(3);
    bus.Tx_Done = 1'b1;
    wait_done(d0 + 1, "ovf_done_to");
    bus.Tx_Done = 1'b0;
    tick(1);
    chk("ovf_sticky", 32'(tx_ovf), 32'd1);

    // abort after 2 of 5 bytes
    clr();
    d0 = done_cnt;
    send_byte(8'h01, 1'b0, 1'b0);
    chk("ab_ovf_clr", 32'(tx_ovf), 32'd0);
    send_byte(8'h02, 1'b0, 1'b0);
    tx_abort = 1'b1;
    tick(1);
    tx_abort = 1'b0;
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0);
    send_byte(8'h05, 1'b1, 1'b0);
    tick(5);
    chk("ab_nwr", wr_log.size(), 3);
    chk("ab_w2", 32'(wr_log[2]), {21'h0, 3'd0, 8'h04});
    chk("ab_nodone", done_cnt, d0);
    chk("ab_idle", 32'(busy), 32'd0);

    // abort together with last
    clr();
    send_byte(8'h31, 1'b0, 1'b0);
    send_byte(8'h32, 1'b1, 1'b1);
    tick(3);
    chk("ablast_nwr", wr_log.size(), 2);
    chk("ablast_w1", 32'(wr_log[1]), {21'h0, 3'd0, 8'h04});
    chk("ablast_idle", 32'(busy), 32'd0);

    // abort in TX_WAIT
    clr();
    d0 = done_cnt;
    send_byte(8'h77, 1'b1, 1'b0);
    wait_wr(2, "abw_go_to");
    tx_abort = 1'b1;
    tick(1);
    tx_abort = 1'b0;
    tick(2);
    chk("abw_nwr", wr_log.size(), 3);
    chk("abw_w2", 32'(wr_log[2]), {21'h0, 3'd0, 8'h04});
    chk("abw_nodone", done_cnt, d0);
    chk("abw_idle", 32'(busy), 32'd0);

    // Tx_Done already high: done 2 cycles after TX_GO
    clr();
    d0 = done_cnt;
    bus.Tx_Done = 1'b1;
    send_byte(8'h44, 1'b1, 1'b0);
    wait_done(d0 + 1, "early_done_to");
    tick(2);
    bus.Tx_Done = 1'b0;
    chk("early_once", done_cnt, d0 + 1);
    chk("early_gap", done_cyc - go_cyc, 2);

    // RX serviced during TX_WAIT
    clr();
    d0 = done_cnt;
    send_byte(8'h66, 1'b1, 1'b0);
    wait_wr(2, "rxw_go_to");
    rx_len_v = 8'd1;
    rx_sc_v  = 8'h00;
    rxbuf.push_back(8'h5A);
    m_rx_ready = 1'b1;
    rx_pulse();
    wait_rx(1, "rxw_out_to");
    m_rx_ready = 1'b0;
    tick(2);
    chk("rxw_o0", 32'(rx_out[0]), 32'h15A);
    chk("rxw_busy", 32'(busy), 32'd1);
    chk("rxw_nodone", done_cnt, d0);
    bus.Tx_Done = 1'b1;
    wait_done(d0 + 1, "rxw_done_to");
    bus.Tx_Done = 1'b0;
    tick(1);
    chk("rxw_idle", 32'(busy), 32'd0);

    // reset in the middle of RX_BYTE
    clr();
    rx_len_v = 8'd3;
    rx_sc_v  = 8'h00;
    rxbuf.push_back(8'hA1);
    rxbuf.push_back(8'hA2);
    rxbuf.push_back(8'hA3);
    rx_pulse();
    wait_mv("rst_mv_to");
    Rst = 1'b0;
    tick(1);
    chk("rst_mid_outs", outs(), 32'h0);
    Rst = 1'b1;
    tick(4);
    chk("rst_mid_idle", 32'(busy), 32'd0);
    chk("rst_mid_mv", 32'(m_rx_valid), 32'd0);

    chk("bus_rules", viol, 0);
    chk("rx_stable", stab_bad, 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/hdlc_host_ctrl.md
Name: hdlc_host_ctrl

Overview:
Synthesizable register-bus initiator that drives the Hdlc controller's Address/WriteEnable/ReadEnable/DataIn/DataOut slave port.
- Turns a byte stream with last flag into a TX frame: writes Tx_Buff, then sets Tx_Enable, then waits for Tx_Done.
- Drains each received frame: reads Rx_Len and Rx_SC, then streams Rx_Buff bytes out.
- Sits between a host/DMA stream fabric and Hdlc; replaces the software register sequence in system-level sims.

Parameters:
RD_LAT, 1, cycles from ReadEnable strobe to valid DataOut (1..3)
MAX_TX_BYTES, 126, bytes accepted per TX frame before overflow

Ports:
Clk  in  1  clock, all logic on rising edge
Rst  in  1  synchronous active-low reset
Address  out  3  Hdlc register address
WriteEnable  out  1  one-cycle write strobe
ReadEnable  out  1  one-cycle read strobe
DataIn  out  8  write data to Hdlc
DataOut  in  8  read data from Hdlc
Rx_Ready  in  1  Hdlc has a complete RX frame buffered
Tx_Done  in  1  Hdlc TX buffer empty/idle
s_tx_data  in  8  TX byte
s_tx_valid  in  1  TX byte valid
s_tx_last  in  1  last byte of frame
s_tx_ready  out  1  TX byte accepted when valid&ready
tx_abort  in  1  pulse: abort current TX frame
m_rx_data  out  8  RX byte
m_rx_valid  out  1  RX byte valid
m_rx_last  out  1  last RX byte
m_rx_ready  in  1  sink ready
tx_frame_done  out  1  one-cycle pulse, TX frame handed off and completed
tx_ovf  out  1  sticky, frame exceeded MAX_TX_BYTES; cleared on next frame start
rx_err  out  1  one-cycle pulse, RX frame dropped (FrameError/Abort/Overflow)
busy  out  1  FSM not IDLE

Behaviour:
- Register map (package): TX_SC=0, TX_BUFF=1, RX_SC=2, RX_BUFF=3, RX_LEN=4.
  - TX_SC bit1 = Tx_Enable, bit2 = Tx_AbortFrame.
  - RX_SC bit1 = Rx_Drop, bit3 = FrameError, bit4 = AbortSignal, bit5 = Overflow.
- Reset (Rst=0 at edge): all outputs 0, FSM=IDLE, counters 0, tx_ovf=0. Applies mid-frame with no bus cleanup.
- Bus rules:
  - At most one of WriteEnable/ReadEnable per cycle; each strobe lasts exactly 1 cycle.
  - Address/DataIn are valid only in the strobe cycle; otherwise Address=0 and DataIn=0.
  - Read data is captured exactly RD_LAT cycles after ReadEnable; no new strobe is issued while a read is outstanding.
- States:
  - IDLE:
    - Rx_Ready=1 -> RX_LEN (RX has priority).
    - Else s_tx_valid=1 -> TX_WR.
  - TX_WR:
    - s_tx_ready=1; each accepted byte issues a write to TX_BUFF in the same cycle. Count is 7-bit.
    - Bytes beyond MAX_TX_BYTES are accepted but not written, and set tx_ovf.
    - s_tx_last accepted -> TX_GO.
  - TX_GO: write TX_SC=0x02, then -> TX_WAIT.
  - TX_WAIT:
    - Tx_Done=1 for the first time, at least 2 cycles after TX_GO -> pulse tx_frame_done, go to IDLE.
    - Rx_Ready=1 -> service RX (RX_LEN...), then return to TX_WAIT.
  - RX_LEN: read RX_LEN -> len (8-bit).
  - RX_STAT: read RX_SC.
    - Bits 3/4/5 any set, or len=0 -> RX_DROP.
    - Else -> RX_BYTE.
  - RX_BYTE:
    - Read RX_BUFF only when the output register is empty or m_rx_ready=1.
    - Present m_rx_data/m_rx_valid, holding them stable until m_rx_ready.
    - m_rx_last is set with byte number len.
    - After the last handshake -> return state.
  - RX_DROP: write RX_SC=0x02, pulse rx_err, -> return state.
- tx_abort:
  - Honoured in TX_WR or TX_WAIT: write TX_SC=0x04, drop remaining input bytes up to and including s_tx_last, no tx_frame_done, -> IDLE.
  - Ignored in IDLE and RX states.
- Simultaneous tx_abort and s_tx_last: the abort wins.
- s_tx_ready=0 outside TX_WR.
- busy=1 in every non-IDLE state.

Decomposition:
- Package hdlc_host_pkg holds:
  - Register address localparams.
  - Status/control bit-index constants.
  - State enum typedef.
- One sub-module, hdlc_reg_rd: issues a read strobe, counts RD_LAT, and returns rd_data with rd_valid. The main FSM uses it for every read.

Test Plan:
- 3-byte TX frame 0xAA,0x55,0x7E with last on 0x7E:
  - Bus shows writes to address 1 with those values, then write addr0=0x02.
  - Drive Tx_Done 10 cycles later -> exactly one tx_frame_done pulse.
- Rx_Ready=1, RX_LEN reads 2, RX_SC reads 0x01, RX_BUFF reads 0x11 then 0x22:
  - m_rx emits 0x11, then 0x22 with m_rx_last.
  - Hold m_rx_ready=0 for 5 cycles mid-frame: data must stay stable and no extra RX_BUFF read is issued.
- RX_SC reads 0x08 (FrameError) -> no m_rx_valid, write addr2=0x02, rx_err pulses once.
- 130-byte TX frame -> exactly 126 TX_BUFF writes, tx_ovf=1, TX_GO still issued.
- tx_abort after 2 bytes of a 5-byte frame:
  - Write addr0=0x04, remaining 3 bytes are consumed with no writes, no tx_frame_done.
  - Rst=0 mid-RX_BYTE: all outputs 0 next cycle, FSM IDLE.
